// File: rtl/four_to_two_encoder_seq.sv
// Registered 4-to-2 priority encoder: captures request pulses into a pending
// register and issues them one code at a time under a valid/ready handshake.
module four_to_two_encoder_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       ready,
    output logic       a,
    output logic       b,
    output logic       valid,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;
    logic [CODE_W-1:0]   pick;
    logic [N_REQ-1:0]    pending_q;
    logic [N_REQ-1:0]    pending_d;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    sel;
    logic [N_REQ-1:0]    clr;
    logic [N_REQ-1:0]    cand;
    logic                accept;
    logic                overflow_q;
    logic                overflow_d;

    assign req      = {d3, d2, d1, d0};
    assign valid    = (state_q == HOLD);
    assign a        = code_q[1];
    assign b        = code_q[0];
    assign pending  = pending_q;
    assign overflow = overflow_q;

    // Request bookkeeping: the issued bit is cleared on accept, new requests win.
    always_comb begin
        sel        = valid ? (N_REQ'(1) << code_q) : '0;
        accept     = valid & ready;
        clr        = accept ? sel : '0;
        cand       = (pending_q & ~clr) | req;
        pending_d  = cand;
        overflow_d = |(req & pending_q & ~clr);
    end

    // Fixed priority pick, index 3 highest.
    always_comb begin
        pick = '0;
        if (cand[3])      pick = CODE_W'(3);
        else if (cand[2]) pick = CODE_W'(2);
        else if (cand[1]) pick = CODE_W'(1);
        else              pick = CODE_W'(0);
    end

    // Next-state and next-code: a held code stays put until it is accepted.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    code_d  = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (|cand) begin
                        code_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_four_to_two_encoder_seq.sv
// Scoreboard bench for four_to_two_encoder_seq: expected codes are queued at
// stimulus time and popped by a monitor on every accepted handshake.
module tb_four_to_two_encoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       d0, d1, d2, d3;
    logic       ready;
    logic       a, b, valid;
    logic [3:0] pending;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];

    four_to_two_encoder_seq dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .ready    (ready),
        .a        (a),
        .b        (b),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {d3, d2, d1, d0} = r;
    endtask

    // Monitor: every accepted handshake must present the next queued code.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL code_unexpected: got %b expected none at %0t", {a, b}, $time);
            end else begin
                check("code", 4'({a, b}), 4'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ready = 1'b0;
        set_req(4'b1000);

        // Reset held with d3 asserted
        tick();
        tick();
        check("rst_pending", pending, 4'b0000);
        check("rst_valid", 4'(valid), 4'd0);
        check("rst_code", 4'({a, b}), 4'd0);
        check("rst_overflow", 4'(overflow), 4'd0);
        rst = 1'b0;
        set_req(4'b0000);
        tick();
        check("post_rst_valid", 4'(valid), 4'd0);
        check("post_rst_pending", pending, 4'b0000);

        // Single request, consumer ready
        set_req(4'b0100);
        ready = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        set_req(4'b0000);
        check("single_valid", 4'(valid), 4'd1);
        check("single_code", 4'({a, b}), 4'b0010);
        check("single_pending", pending, 4'b0100);
        tick();
        check("single_done_valid", 4'(valid), 4'd0);
        check("single_done_pending", pending, 4'b0000);

        // Multi-hot burst served in priority order after a stall
        ready = 1'b0;
        set_req(4'b1011);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        tick();
        set_req(4'b0000);
        for (int i = 0; i < 3; i++) begin
            check("multi_hold_code", 4'({a, b}), 4'b0011);
            check("multi_hold_pending", pending, 4'b1011);
            if (i < 2) tick();
        end
        ready = 1'b1;
        tick();
        check("multi_code1", 4'({a, b}), 4'b0001);
        check("multi_pending1", pending, 4'b0011);
        tick();
        check("multi_code0", 4'({a, b}), 4'b0000);
        check("multi_pending0", pending, 4'b0001);
        tick();
        check("multi_done_valid", 4'(valid), 4'd0);
        check("multi_done_pending", pending, 4'b0000);
        ready = 1'b0;

        // Held code stays stable when a higher priority request arrives
        set_req(4'b0010);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        tick();
        set_req(4'b1000);
        check("hold_code_d1", 4'({a, b}), 4'b0001);
        tick();
        set_req(4'b0000);
        check("hold_code_stable", 4'({a, b}), 4'b0001);
        check("hold_pending", pending, 4'b1010);
        ready = 1'b1;
        tick();
        check("hold_next_code", 4'({a, b}), 4'b0011);
        check("hold_next_pending", pending, 4'b1000);
        tick();
        check("hold_done_valid", 4'(valid), 4'd0);
        ready = 1'b0;

        // Overflow on duplicate request, set-wins in the accept cycle
        set_req(4'b0100);
        exp_q.push_back(2'b10);
        tick();
        set_req(4'b0000);
        check("ovf_first_valid", 4'(valid), 4'd1);
        check("ovf_first_overflow", 4'(overflow), 4'd0);
        tick();
        set_req(4'b0100);
        tick();
        set_req(4'b0000);
        check("ovf_pulse", 4'(overflow), 4'd1);
        check("ovf_pending", pending, 4'b0100);
        tick();
        check("ovf_pulse_end", 4'(overflow), 4'd0);
        check("ovf_pending_kept", pending, 4'b0100);
        ready = 1'b1;
        set_req(4'b0100);
        exp_q.push_back(2'b10);
        tick();
        set_req(4'b0000);
        check("setwin_overflow", 4'(overflow), 4'd0);
        check("setwin_valid", 4'(valid), 4'd1);
        check("setwin_code", 4'({a, b}), 4'b0010);
        check("setwin_pending", pending, 4'b0100);
        tick();
        check("setwin_done_valid", 4'(valid), 4'd0);
        check("setwin_done_pending", pending, 4'b0000);
        ready = 1'b0;

        // Reset mid-operation discards the held code
        set_req(4'b1100);
        tick();
        set_req(4'b0000);
        check("mid_valid", 4'(valid), 4'd1);
        check("mid_pending", pending, 4'b1100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 4'(valid), 4'd0);
        check("mid_rst_pending", pending, 4'b0000);
        check("mid_rst_overflow", 4'(overflow), 4'd0);
        set_req(4'b0010);
        ready = 1'b1;
        exp_q.push_back(2'b01);
        tick();
        set_req(4'b0000);
        check("after_rst_valid", 4'(valid), 4'd1);
        check("after_rst_code", 4'({a, b}), 4'b0001);
        tick();
        check("after_rst_done", 4'(valid), 4'd0);
        ready = 1'b0;

        tick();
        tick();
        check("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
